// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state type and tile arithmetic for the matmul sequencer
package matmul_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_ISSUE,
      S_WAIT_STEP,
      S_WAIT_ACC,
      S_WRITE,
      S_DONE
   } seq_state_t;

   // Counter width for a count of n values; never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int k_tiles(input int inner_dim, input int block_size);
      return inner_dim / block_size;
   endfunction

   function automatic int r_tiles(input int i_outer_dim, input int block_size, input int num_cores);
      return i_outer_dim / (block_size * num_cores);
   endfunction

   function automatic int c_tiles(input int w_outer_dim, input int block_size);
      return w_outer_dim / block_size;
   endfunction

endpackage

// File: rtl/tile_index_counter.sv
// rtl/tile_index_counter.sv - nested row/column tile index counter with selectable loop order
module tile_index_counter
   import matmul_pkg::*;
#(
   parameter int R_TILES   = 3,
   parameter int C_TILES   = 3,
   parameter int COL_INNER = 1,
   parameter int RW        = cnt_width(R_TILES),
   parameter int CW        = cnt_width(C_TILES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          advance,
   output logic [RW-1:0] r,
   output logic [CW-1:0] c,
   output logic          last_tile
);

   logic r_end;
   logic c_end;

   assign r_end     = (r == RW'(R_TILES - 1));
   assign c_end     = (c == CW'(C_TILES - 1));
   assign last_tile = r_end && c_end;

   // Step the inner index every advance; the outer index moves when the inner one wraps
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r <= '0;
         c <= '0;
      end else if (advance) begin
         if (COL_INNER != 0) begin
            c <= c_end ? '0 : c + 1'b1;
            if (c_end) r <= r_end ? '0 : r + 1'b1;
         end else begin
            r <= r_end ? '0 : r + 1'b1;
            if (r_end) c <= c_end ? '0 : c + 1'b1;
         end
      end
   end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// rtl/matmul_tile_sequencer.sv - tile-by-tile BRAM fetch, core handshake and C-tile write sequencer
module matmul_tile_sequencer
   import matmul_pkg::*;
#(
   parameter int BLOCK_SIZE        = 2,
   parameter int INNER_DIMENSION   = 4,
   parameter int I_OUTER_DIMENSION = 6,
   parameter int W_OUTER_DIMENSION = 6,
   parameter int NUM_CORES         = 1,
   parameter int COL_INNER         = 1,
   parameter int ADDR_WIDTH_I      = 14,
   parameter int ADDR_WIDTH_W      = 12,
   parameter int ADDR_WIDTH_O      = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic                    in_rd_en,
   output logic [ADDR_WIDTH_I-1:0] in_addr,
   output logic                    w_rd_en,
   output logic [ADDR_WIDTH_W-1:0] w_addr,
   output logic                    core_valid,
   output logic                    core_last,
   input  logic                    step_done,
   input  logic                    acc_done,
   output logic                    out_we,
   output logic [ADDR_WIDTH_O-1:0] out_addr,
   input  logic                    out_ready
);

   localparam int K_TILES = k_tiles(INNER_DIMENSION, BLOCK_SIZE);
   localparam int R_TILES = r_tiles(I_OUTER_DIMENSION, BLOCK_SIZE, NUM_CORES);
   localparam int C_TILES = c_tiles(W_OUTER_DIMENSION, BLOCK_SIZE);
   localparam int KW      = cnt_width(K_TILES);
   localparam int RW      = cnt_width(R_TILES);
   localparam int CW      = cnt_width(C_TILES);
   localparam int MAX_IN  = K_TILES * R_TILES - 1;
   localparam int MAX_W   = K_TILES * C_TILES - 1;
   localparam int MAX_O   = R_TILES * C_TILES - 1;

   if ((INNER_DIMENSION % BLOCK_SIZE) != 0) begin : g_bad_inner
      $error("INNER_DIMENSION must be a multiple of BLOCK_SIZE");
   end
   if ((I_OUTER_DIMENSION % (BLOCK_SIZE * NUM_CORES)) != 0) begin : g_bad_rows
      $error("I_OUTER_DIMENSION must be a multiple of BLOCK_SIZE*NUM_CORES");
   end
   if (longint'(MAX_IN) >= (longint'(1) << ADDR_WIDTH_I)) begin : g_bad_in_width
      $error("input address does not fit ADDR_WIDTH_I");
   end
   if (longint'(MAX_W) >= (longint'(1) << ADDR_WIDTH_W)) begin : g_bad_w_width
      $error("weight address does not fit ADDR_WIDTH_W");
   end
   if (longint'(MAX_O) >= (longint'(1) << ADDR_WIDTH_O)) begin : g_bad_o_width
      $error("output address does not fit ADDR_WIDTH_O");
   end

   seq_state_t    state;
   seq_state_t    state_nxt;
   logic [KW-1:0] k;
   logic          k_last;
   logic          err_q;
   logic [RW-1:0] r;
   logic [CW-1:0] c;
   logic          last_tile;
   logic          tile_clear;
   logic          tile_advance;

   assign k_last       = (k == KW'(K_TILES - 1));
   assign tile_clear   = (state == S_IDLE) && start;
   assign tile_advance = (state == S_WRITE) && out_ready;
   assign err          = err_q;

   tile_index_counter #(
      .R_TILES   (R_TILES),
      .C_TILES   (C_TILES),
      .COL_INNER (COL_INNER),
      .RW        (RW),
      .CW        (CW)
   ) u_tile_idx (
      .clk       (clk),
      .rst       (rst),
      .clear     (tile_clear),
      .advance   (tile_advance),
      .r         (r),
      .c         (c),
      .last_tile (last_tile)
   );

   // State register; reset aborts any run without a done pulse
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // K-step counter and sticky protocol error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         k     <= '0;
         err_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  k     <= '0;
                  err_q <= 1'b0;
               end
            end
            S_WAIT_STEP: begin
               if (step_done) k <= k + 1'b1;
               if (acc_done)  err_q <= 1'b1;
            end
            S_WAIT_ACC: begin
               if (acc_done) k <= '0;
            end
            default: ;
         endcase
      end
   end

   // Next-state selection
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:      if (start) state_nxt = S_FETCH;
         S_FETCH:     state_nxt = S_LOAD;
         S_LOAD:      state_nxt = S_ISSUE;
         S_ISSUE:     state_nxt = k_last ? S_WAIT_ACC : S_WAIT_STEP;
         S_WAIT_STEP: if (step_done) state_nxt = S_FETCH;
         S_WAIT_ACC:  if (acc_done) state_nxt = S_WRITE;
         S_WRITE:     if (out_ready) state_nxt = last_tile ? S_DONE : S_FETCH;
         S_DONE:      state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state; addresses are only driven while they are consumed
   always_comb begin
      busy       = (state != S_IDLE) && (state != S_DONE);
      done       = 1'b0;
      in_rd_en   = 1'b0;
      w_rd_en    = 1'b0;
      in_addr    = '0;
      w_addr     = '0;
      core_valid = 1'b0;
      core_last  = 1'b0;
      out_we     = 1'b0;
      out_addr   = '0;
      unique case (state)
         S_FETCH: begin
            in_rd_en = 1'b1;
            w_rd_en  = 1'b1;
            in_addr  = ADDR_WIDTH_I'(k) + ADDR_WIDTH_I'(K_TILES) * ADDR_WIDTH_I'(r);
            w_addr   = ADDR_WIDTH_W'(k) + ADDR_WIDTH_W'(K_TILES) * ADDR_WIDTH_W'(c);
         end
         S_ISSUE: begin
            core_valid = 1'b1;
            core_last  = k_last;
         end
         S_WRITE: begin
            out_we   = out_ready;
            out_addr = ADDR_WIDTH_O'(r) * ADDR_WIDTH_O'(C_TILES) + ADDR_WIDTH_O'(c);
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb/tb_matmul_tile_sequencer.sv - self-checking bench for matmul_tile_sequencer
`timescale 1ns/1ps
module tb_matmul_tile_sequencer;

   localparam int NI = 3;

   int vectors    = 0;
   int miscompares = 0;

   logic          clk = 1'b0;
   logic [NI-1:0] start_v = '0;
   logic [NI-1:0] rst_v = '1;
   logic [NI-1:0] inj_v = '0;
   logic          rdy0 = 1'b1;

   int lit_in0[8]  = '{0, 1, 0, 1, 0, 1, 2, 3};
   int lit_w0[8]   = '{0, 1, 2, 3, 4, 5, 0, 1};
   int lit_out1[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};

   always #5 clk = ~clk;

   function automatic void chk(input int inst, input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL dut%0d %s: got %0d, expected %0d", inst, name, act, exp);
      end
   endfunction

   // Instance configurations: 0 default, 1 row-innermost order, 2 two cores with 8x8 outer dims
   function automatic int p_ci(input int i); return (i == 1) ? 0 : 1; endfunction
   function automatic int p_nc(input int i); return (i == 2) ? 2 : 1; endfunction
   function automatic int p_io(input int i); return (i == 2) ? 8 : 6; endfunction
   function automatic int p_wo(input int i); return (i == 2) ? 8 : 6; endfunction

   // Tile t of the run, as a (row, col) pair in the selected loop order
   function automatic int tile_r(input int t, input int ci, input int rt, input int ct);
      return (ci != 0) ? t / ct : t % rt;
   endfunction
   function automatic int tile_c(input int t, input int ci, input int rt, input int ct);
      return (ci != 0) ? t % ct : t / rt;
   endfunction
   // Fetch n belongs to tile n/K at K step n%K (K = 2 for every instance)
   function automatic int exp_in(input int n, input int ci, input int rt, input int ct);
      return (n % 2) + 2 * tile_r(n / 2, ci, rt, ct);
   endfunction
   function automatic int exp_w(input int n, input int ci, input int rt, input int ct);
      return (n % 2) + 2 * tile_c(n / 2, ci, rt, ct);
   endfunction
   function automatic int exp_out(input int m, input int ci, input int rt, input int ct);
      return tile_r(m, ci, rt, ct) * ct + tile_c(m, ci, rt, ct);
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g
      localparam int CI = p_ci(gi);
      localparam int NC = p_nc(gi);
      localparam int IO = p_io(gi);
      localparam int WO = p_wo(gi);
      localparam int RT = IO / (2 * NC);
      localparam int CT = WO / 2;

      logic        busy, done, err, in_rd_en, w_rd_en, core_valid, core_last, out_we;
      logic        step_done, acc_done;
      logic [13:0] in_addr;
      logic [11:0] w_addr;
      logic [11:0] out_addr;
      logic        resp_step = 1'b0;
      logic        resp_acc = 1'b0;
      logic        kind_last = 1'b0;
      int          cd = 0;
      int          nf = 0, nw = 0, ni = 0, ndone = 0;
      bit          running = 1'b0;
      int          obs_in[$], obs_w[$], obs_out[$];

      matmul_tile_sequencer #(
         .BLOCK_SIZE        (2),
         .INNER_DIMENSION   (4),
         .I_OUTER_DIMENSION (IO),
         .W_OUTER_DIMENSION (WO),
         .NUM_CORES         (NC),
         .COL_INNER         (CI),
         .ADDR_WIDTH_I      (14),
         .ADDR_WIDTH_W      (12),
         .ADDR_WIDTH_O      (12)
      ) u_dut (
         .clk        (clk),
         .rst        (rst_v[gi]),
         .start      (start_v[gi]),
         .busy       (busy),
         .done       (done),
         .err        (err),
         .in_rd_en   (in_rd_en),
         .in_addr    (in_addr),
         .w_rd_en    (w_rd_en),
         .w_addr     (w_addr),
         .core_valid (core_valid),
         .core_last  (core_last),
         .step_done  (step_done),
         .acc_done   (acc_done),
         .out_we     (out_we),
         .out_addr   (out_addr),
         .out_ready  ((gi == 0) ? rdy0 : 1'b1)
      );

      assign step_done = resp_step;
      assign acc_done  = resp_acc | inj_v[gi];

      // Core model: answer each issued tile step five cycles later
      always @(posedge clk) begin
         resp_step <= 1'b0;
         resp_acc  <= 1'b0;
         if (rst_v[gi]) begin
            cd <= 0;
         end else if (core_valid) begin
            cd        <= 5;
            kind_last <= core_last;
         end else if (cd > 0) begin
            cd <= cd - 1;
            if (cd == 1) begin
               resp_step <= !kind_last;
               resp_acc  <= kind_last;
            end
         end
      end

      // Compare process: every fetch, issue and write against the loop-nest model
      always @(negedge clk) begin
         if (rst_v[gi]) begin
            nf = 0; nw = 0; ni = 0;
            running = 1'b0;
         end else begin
            chk(gi, "busy", int'(busy), int'(running && !done));
            if (start_v[gi] && !running) begin
               nf = 0; nw = 0; ni = 0;
               running = 1'b1;
               obs_in.delete(); obs_w.delete(); obs_out.delete();
            end
            if (in_rd_en) begin
               chk(gi, "in_addr", int'(in_addr), exp_in(nf, CI, RT, CT));
               chk(gi, "w_addr", int'(w_addr), exp_w(nf, CI, RT, CT));
               chk(gi, "w_rd_en", int'(w_rd_en), 1);
               obs_in.push_back(int'(in_addr));
               obs_w.push_back(int'(w_addr));
               nf++;
            end
            if (core_valid) begin
               chk(gi, "core_last", int'(core_last), int'((ni % 2) == 1));
               ni++;
            end
            if (out_we) begin
               chk(gi, "out_addr", int'(out_addr), exp_out(nw, CI, RT, CT));
               obs_out.push_back(int'(out_addr));
               nw++;
            end
            if (done) begin
               chk(gi, "writes_at_done", nw, RT * CT);
               chk(gi, "fetches_at_done", nf, RT * CT * 2);
               ndone++;
               running = 1'b0;
            end
         end
      end
   end

   task automatic pulse_start(input logic [NI-1:0] m);
      @(posedge clk); #1;
      start_v = m;
      @(posedge clk); #1;
      start_v = '0;
   endtask

   task automatic wait_done0(input int base, input string name);
      int cyc;
      cyc = 0;
      while (g[0].ndone == base && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk(0, name, int'(cyc < 2000), 1);
      repeat (3) @(negedge clk);
      chk(0, "done_once", g[0].ndone, base + 1);
      chk(0, "busy_after_done", int'(g[0].busy), 0);
   endtask

   initial begin
      int base;
      int cyc;

      // Pin the model against hand-computed points of the loop nest
      chk(0, "model_in6", exp_in(6, 1, 3, 3), 2);
      chk(0, "model_w7", exp_w(7, 1, 3, 3), 1);
      chk(1, "model_out5", exp_out(5, 0, 3, 3), 7);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk(0, "rst_ctrl", int'({g[0].busy, g[0].done, g[0].err, g[0].in_rd_en, g[0].w_rd_en,
                               g[0].core_valid, g[0].core_last, g[0].out_we}), 0);
      chk(0, "rst_addr", int'(g[0].in_addr) + int'(g[0].w_addr) + int'(g[0].out_addr), 0);
      chk(1, "rst_busy", int'(g[1].busy | g[1].done), 0);
      chk(2, "rst_busy", int'(g[2].busy | g[2].done), 0);
      rst_v = '0;

      // Nominal run on all three configurations
      pulse_start('1);
      cyc = 0;
      while (!(g[0].ndone == 1 && g[1].ndone == 1 && g[2].ndone == 1) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk(0, "nominal_timeout", int'(cyc < 2000), 1);
      repeat (3) @(negedge clk);
      chk(0, "nom_done", g[0].ndone, 1);
      chk(1, "nom_done", g[1].ndone, 1);
      chk(2, "nom_done", g[2].ndone, 1);
      chk(0, "nom_fetches", g[0].obs_in.size(), 18);
      chk(0, "nom_writes", g[0].obs_out.size(), 9);
      chk(1, "nom_writes", g[1].obs_out.size(), 9);
      chk(2, "nom_writes", g[2].obs_out.size(), 8);
      chk(2, "nom_fetches", g[2].obs_in.size(), 16);
      chk(0, "nom_err", int'(g[0].err), 0);
      if (g[0].obs_in.size() >= 8) begin
         for (int j = 0; j < 8; j++) begin
            chk(0, "lit_in_seq", g[0].obs_in[j], lit_in0[j]);
            chk(0, "lit_w_seq", g[0].obs_w[j], lit_w0[j]);
         end
      end
      if (g[1].obs_out.size() == 9) begin
         for (int j = 0; j < 9; j++) begin
            chk(1, "lit_out_seq", g[1].obs_out[j], lit_out1[j]);
            chk(0, "lit_out_seq", g[0].obs_out[j], j);
         end
      end

      // Backpressure on the tile written to address 4
      base = g[0].ndone;
      pulse_start(3'b001);
      cyc = 0;
      while (g[0].nw < 4 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk(0, "bp_reach", int'(cyc < 2000), 1);
      @(posedge clk); #1;
      rdy0 = 1'b0;
      cyc = 0;
      while (!g[0].acc_done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk(0, "bp_acc", int'(cyc < 2000), 1);
      for (int j = 0; j < 4; j++) begin
         @(posedge clk); #1;
         chk(0, "bp_we_low", int'(g[0].out_we), 0);
         chk(0, "bp_addr_hold", int'(g[0].out_addr), 4);
      end
      rdy0 = 1'b1;
      wait_done0(base, "bp_timeout");
      chk(0, "bp_writes", g[0].obs_out.size(), 9);

      // Protocol error: acc_done while waiting for the k=0 step
      base = g[0].ndone;
      pulse_start(3'b001);
      cyc = 0;
      while (!g[0].core_valid && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk(0, "err_issue", int'(cyc < 2000), 1);
      @(posedge clk); #1;
      inj_v[0] = 1'b1;
      @(posedge clk); #1;
      inj_v[0] = 1'b0;
      @(negedge clk);
      chk(0, "err_set", int'(g[0].err), 1);
      wait_done0(base, "err_timeout");
      chk(0, "err_sticky", int'(g[0].err), 1);
      chk(0, "err_writes", g[0].obs_out.size(), 9);

      // Reset during WAIT_STEP of the tile written to address 5
      base = g[0].ndone;
      pulse_start(3'b001);
      @(negedge clk);
      chk(0, "err_cleared", int'(g[0].err), 0);
      cyc = 0;
      while (g[0].nf < 11 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk(0, "rst_reach", int'(cyc < 2000), 1);
      cyc = 0;
      while (!g[0].core_valid && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      @(posedge clk); #1;
      rst_v[0] = 1'b1;
      @(posedge clk); #1;
      rst_v[0] = 1'b0;
      chk(0, "midrst_ctrl", int'({g[0].busy, g[0].done, g[0].err, g[0].in_rd_en, g[0].w_rd_en,
                                  g[0].core_valid, g[0].core_last, g[0].out_we}), 0);
      chk(0, "midrst_addr", int'(g[0].in_addr) + int'(g[0].w_addr) + int'(g[0].out_addr), 0);
      repeat (10) @(negedge clk);
      chk(0, "midrst_no_done", g[0].ndone, base);

      // Fresh run with start pulsed while busy
      pulse_start(3'b001);
      repeat (20) @(posedge clk);
      pulse_start(3'b001);
      repeat (50) @(posedge clk);
      pulse_start(3'b001);
      wait_done0(base, "restart_timeout");
      chk(0, "restart_writes", g[0].obs_out.size(), 9);
      if (g[0].obs_in.size() > 0) chk(0, "restart_in0", g[0].obs_in[0], 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/matmul_tile_sequencer.md
Name: matmul_tile_sequencer

Overview:
- Parametrised successor of the single-core matmul top-level controller.
- Sequences input-BRAM and weight-BRAM read addresses tile by tile, and hands each fetched tile pair to the systolic/accumulator core with a valid/last handshake.
- Waits for the core's step and accumulate completions, then writes each finished C-tile to an output buffer address under backpressure.
- Replaces the ad-hoc edge-triggered counters with one clocked FSM, supports multi-core row groups and selectable loop order, and reports start/busy/done.

Parameters:
- BLOCK_SIZE, 2: systolic array dimension N (tile is N x N).
- INNER_DIMENSION, 4: shared dimension K; must be divisible by BLOCK_SIZE.
- I_OUTER_DIMENSION, 6: rows of input matrix A.
- W_OUTER_DIMENSION, 6: columns of weight matrix B.
- NUM_CORES, 1: row tiles delivered per input-BRAM word; I_OUTER_DIMENSION must be divisible by BLOCK_SIZE*NUM_CORES.
- COL_INNER, 1: 1 = column index innermost (row-major C output); 0 = row index innermost.
- ADDR_WIDTH_I, 14: input BRAM address width.
- ADDR_WIDTH_W, 12: weight BRAM address width.
- ADDR_WIDTH_O, 12: output buffer address width.
- Derived localparams: K_TILES = INNER_DIMENSION/BLOCK_SIZE; R_TILES = I_OUTER_DIMENSION/(BLOCK_SIZE*NUM_CORES); C_TILES = W_OUTER_DIMENSION/BLOCK_SIZE.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a full matmul; sampled only in IDLE.
- busy  out  1  high from the first cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last output write.
- err  out  1  sticky protocol error; cleared by rst or by an accepted start.
- in_rd_en  out  1  input BRAM port-B enable.
- in_addr  out  ADDR_WIDTH_I  input BRAM read address.
- w_rd_en  out  1  weight BRAM port-B enable.
- w_addr  out  ADDR_WIDTH_W  weight BRAM read address.
- core_valid  out  1  one-cycle pulse: BRAM data on doutb is valid for the core.
- core_last  out  1  qualifies core_valid; marks the final K step of a tile.
- step_done  in  1  pulse from core: systolic pass finished (systolic_finish).
- acc_done  in  1  pulse from core: accumulation complete, tile ready (accumulator_done).
- out_we  out  1  output-buffer write strobe.
- out_addr  out  ADDR_WIDTH_O  C-tile index.
- out_ready  in  1  output buffer can accept the write.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, counters k/r/c are 0. Reset mid-operation aborts immediately; no done pulse is generated.
- States and transitions:
  - IDLE: on start go to FETCH; busy=1 next cycle; err cleared; k, r, c cleared.
  - FETCH (1 cycle): in_rd_en=w_rd_en=1; in_addr = k + K_TILES*r; w_addr = k + K_TILES*c. Go to LOAD.
  - LOAD (1 cycle): covers BRAM read latency 1. Go to ISSUE.
  - ISSUE (1 cycle): core_valid=1; core_last=(k==K_TILES-1). Go to WAIT_ACC if last, else WAIT_STEP.
  - WAIT_STEP: on step_done, k++, go to FETCH. acc_done here sets err and is otherwise ignored.
  - WAIT_ACC: on acc_done, k=0, go to WRITE. A step_done arriving here is ignored.
  - WRITE: out_addr = r*C_TILES + c; out_we = out_ready. Hold state and address while out_ready=0.
  - After an accepted write: if the tile was last (r==R_TILES-1 and c==C_TILES-1), go to DONE; otherwise advance the tile indices and go to FETCH.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Tile advance:
  - COL_INNER=1: c wraps at C_TILES-1 and r increments.
  - COL_INNER=0: r wraps at R_TILES-1 and c increments.
- start while busy is ignored.
- step_done and acc_done in the same cycle: WAIT_STEP applies the err rule; WAIT_ACC proceeds normally.
- Addresses are computed at full index width, then truncated to the port width. An elaboration-time check fails if the maximum address does not fit.
- Minimum latency per tile: 3*K_TILES cycles plus core time plus 1 write cycle.

Decomposition:
- Shared package matmul_pkg: FSM state enum; clog2-based helper functions for counter widths; tile-count computations shared with toplevel and the future output reorder buffer.
- One natural sub-module: tile_index_counter. It is a nested r/c wrap counter with the COL_INNER parameter, and exposes last_tile and advance ports.

Test Plan (defaults: K_TILES=2, R_TILES=3, C_TILES=3):
- Nominal run: start; a core model answers step_done/acc_done 5 cycles after core_valid. Expect 18 FETCHes, in_addr sequence 0,1,0,1,0,1,2,3,..., w_addr sequence 0,1,2,3,4,5,0,1,..., out_addr 0..8 in order, then done exactly once, busy then low.
- COL_INNER=0: same stimulus. Expect out_addr order 0,3,6,1,4,7,2,5,8.
- Backpressure: out_ready held 0 for 4 cycles at the tile with out_addr=4. Expect out_we=0 and out_addr stable at 4 throughout, then a single write and normal continuation.
- Protocol error: inject acc_done while k=0 in WAIT_STEP. Expect err=1 and sticky, the sequence otherwise unchanged; err clears on the next accepted start.
- Reset mid-run: assert rst during WAIT_STEP of the tile with out_addr=5. Next cycle all outputs are 0 and the FSM is IDLE; a fresh start restarts from addresses 0.
- start pulsed while busy: ignored, with the out_addr sequence unaltered. NUM_CORES=2, I_OUTER_DIMENSION=8: expect R_TILES=2 and 8 output writes.
